// File: rtl/shufflev_rng_multi.sv
// Multi-channel xorshift32 uniform random source with per-channel valid/ready output registers.
// Optional exact-uniform rejection sampling: define SHUFFLEV_RNG_REJECT_EN.
module shufflev_rng_multi #(
  parameter int          Channels = 2,
  parameter int          MaxValue = 4,
  parameter logic [31:0] RngSeed  = 32'd123456,
  localparam int         NB       = $clog2(MaxValue + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   reseed_i,
  input  logic [31:0]            seed_i,
  input  logic [Channels-1:0]    ready_i,
  output logic [Channels-1:0]    valid_o,
  output logic [Channels*NB-1:0] number_o,
  output logic                   seeded_o,
  output logic [15:0]            reject_cnt_o
);

  localparam logic [NB-1:0] MaxV = NB'(MaxValue);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEED,
    S_RUN
  } state_e;

  state_e      state_q, state_d;
  logic        run, seed_load, reseed_go;
  logic [31:0] base_q;

  function automatic logic [31:0] xs32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_SEED;
      S_SEED:  state_d = S_RUN;
      S_RUN:   if (reseed_i) state_d = S_SEED;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    run       = (state_q == S_RUN);
    seed_load = (state_q == S_SEED);
    reseed_go = run && reseed_i;
    seeded_o  = run;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)          base_q <= RngSeed;
    else if (reseed_go) base_q <= seed_i;
  end

`ifdef SHUFFLEV_RNG_REJECT_EN
  logic [Channels-1:0] rej;
`endif

  for (genvar c = 0; c < Channels; c++) begin : g_ch
    logic [31:0]   x_q, x_d, x_step, x_seed;
    logic [NB-1:0] cand, val, num_q, num_d;
    logic          acc, valid_q, valid_d;

    always_comb begin
      x_step = xs32(x_q);
      x_seed = base_q ^ (32'(c) * 32'h9E3779B9);
      if (x_seed == '0) x_seed = 32'h0000_0001;
      cand = x_step[NB-1:0];
`ifdef SHUFFLEV_RNG_REJECT_EN
      acc = (cand <= MaxV);
      val = cand;
`else
      // 2^NB < 2*(MaxValue+1), so one subtraction always lands in range
      acc = 1'b1;
      val = (cand > MaxV) ? (cand - MaxV - NB'(1)) : cand;
`endif
      x_d     = x_q;
      num_d   = num_q;
      valid_d = valid_q;
      if (seed_load) begin
        x_d = x_seed;
      end else if (run) begin
        x_d = x_step;
        if (reseed_go) begin
          valid_d = 1'b0;
        end else if (acc && (!valid_q || ready_i[c])) begin
          num_d   = val;
          valid_d = 1'b1;
        end else if (valid_q && ready_i[c]) begin
          valid_d = 1'b0;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        x_q     <= '0;
        num_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        x_q     <= x_d;
        num_q   <= num_d;
        valid_q <= valid_d;
      end
    end

    assign valid_o[c]             = valid_q;
    assign number_o[c*NB +: NB]   = num_q;
`ifdef SHUFFLEV_RNG_REJECT_EN
    assign rej[c]                 = run && !acc;
`endif
  end

`ifdef SHUFFLEV_RNG_REJECT_EN
  logic [15:0] rcnt_q, rcnt_d;
  logic [16:0] rsum;

  always_comb begin
    rsum   = 17'(rcnt_q) + 17'($countones(rej));
    rcnt_d = (rsum > 17'h0FFFF) ? 16'hFFFF : rsum[15:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rcnt_q <= '0;
    else       rcnt_q <= rcnt_d;
  end

  assign reject_cnt_o = rcnt_q;
`else
  assign reject_cnt_o = '0;
`endif

endmodule

// File: tb/tb_shufflev_rng_multi.sv
// Self-checking bench for shufflev_rng_multi: cycle-level reference model plus scenario tasks.
module tb_shufflev_rng_multi;
  localparam int CH = 4;
  localparam int MV = 4;
  localparam int NB = $clog2(MV + 1);
  localparam int NCAND = 1 << NB;

  logic              clk = 1'b0;
  logic              rst, reseed;
  logic [31:0]       seed;
  logic [CH-1:0]     ready;
  logic [CH-1:0]     valid_o;
  logic [CH*NB-1:0]  number_o;
  logic              seeded_o;
  logic [15:0]       reject_cnt_o;

  int checks = 0;
  int failures = 0;

  shufflev_rng_multi #(.Channels(CH), .MaxValue(MV), .RngSeed(32'd0)) dut (
    .clk_i(clk), .rst_i(rst), .reseed_i(reseed), .seed_i(seed), .ready_i(ready),
    .valid_o(valid_o), .number_o(number_o), .seeded_o(seeded_o), .reject_cnt_o(reject_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: 0 = IDLE, 1 = SEED, 2 = RUN
  int          m_st;
  logic [31:0] m_base;
  logic [31:0] m_x [CH];
  bit          m_v [CH];
  int          m_n [CH];
  int          m_rej;
  int          ref_seq[$];

  function automatic logic [31:0] xorshift(input logic [31:0] x);
    x = x ^ (x << 13);
    x = x ^ (x >> 17);
    x = x ^ (x << 5);
    return x;
  endfunction

  function automatic int dnum(input int c);
    return int'(number_o[c*NB +: NB]);
  endfunction

  task automatic model_edge();
    int cand, v;
    bit acc;
    if (rst) begin
      m_st = 0; m_base = 32'd0; m_rej = 0;
      for (int c = 0; c < CH; c++) begin m_x[c] = 0; m_v[c] = 0; m_n[c] = 0; end
    end else if (m_st == 0) begin
      m_st = 1;
    end else if (m_st == 1) begin
      for (int c = 0; c < CH; c++) begin
        m_x[c] = m_base ^ (c * 32'h9E3779B9);
        if (m_x[c] == 0) m_x[c] = 1;
      end
      m_st = 2;
    end else begin
      for (int c = 0; c < CH; c++) begin
        m_x[c] = xorshift(m_x[c]);
        cand = int'(m_x[c] % NCAND);
`ifdef SHUFFLEV_RNG_REJECT_EN
        acc = (cand <= MV);
        v = cand;
`else
        acc = 1;
        v = (cand > MV) ? cand - (MV + 1) : cand;
`endif
        if (!acc && m_rej < 65535) m_rej++;
        if (reseed) m_v[c] = 0;
        else if (acc && (!m_v[c] || ready[c])) begin m_n[c] = v; m_v[c] = 1; end
        else if (m_v[c] && ready[c]) m_v[c] = 0;
      end
      if (reseed) begin m_base = seed; m_st = 1; end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; reseed = 0; seed = 0; ready = '1;
    cycle(); cycle();
    checks++; if (seeded_o !== 1'b0) begin failures++; $display("FAIL reset_seeded got=%0b exp=0", seeded_o); end
    checks++; if (valid_o !== '0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    checks++; if (number_o !== '0) begin failures++; $display("FAIL reset_number got=%h exp=0", number_o); end
    checks++; if (reject_cnt_o !== 16'd0) begin failures++; $display("FAIL reset_rejcnt got=%0d exp=0", reject_cnt_o); end
  endtask

  task automatic test_startup();
    rst = 0; ready = '1;
    cycle();
    checks++; if (seeded_o !== 1'b0) begin failures++; $display("FAIL edge1_seeded got=%0b exp=0", seeded_o); end
    cycle();
    checks++; if (seeded_o !== 1'b1) begin failures++; $display("FAIL edge2_seeded got=%0b exp=1", seeded_o); end
    checks++; if (valid_o !== '0) begin failures++; $display("FAIL edge2_valid got=%b exp=0", valid_o); end
    ref_seq.delete();
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (k == 0) begin
        // seed 0 -> 1, xorshift32(1)=0x00042021, low bits give 1
        checks++; if (valid_o[0] !== 1'b1 || dnum(0) != 1) begin
          failures++; $display("FAIL edge3_first got=v%0b/%0d exp=v1/1", valid_o[0], dnum(0));
        end
      end
      for (int c = 0; c < CH; c++) begin
        checks++; if (valid_o[c] !== m_v[c] || dnum(c) != m_n[c]) begin
          failures++; $display("FAIL startup_ch%0d got=v%0b/%0d exp=v%0b/%0d", c, valid_o[c], dnum(c), m_v[c], m_n[c]);
        end
      end
      if (m_v[0]) ref_seq.push_back(m_n[0]);
    end
  endtask

  task automatic test_backpressure();
    int snap_n [CH];
    bit snap_v [CH];
    ready = '0;
    cycle();
    for (int c = 0; c < CH; c++) begin snap_n[c] = dnum(c); snap_v[c] = valid_o[c]; end
    for (int k = 0; k < 10; k++) begin
      cycle();
      for (int c = 0; c < CH; c++) begin
        checks++; if (valid_o[c] !== m_v[c] || dnum(c) != m_n[c]) begin
          failures++; $display("FAIL stall_ch%0d got=v%0b/%0d exp=v%0b/%0d", c, valid_o[c], dnum(c), m_v[c], m_n[c]);
        end
        if (snap_v[c]) begin
          checks++; if (valid_o[c] !== 1'b1 || dnum(c) != snap_n[c]) begin
            failures++; $display("FAIL stall_hold_ch%0d got=v%0b/%0d exp=v1/%0d", c, valid_o[c], dnum(c), snap_n[c]);
          end
        end
      end
    end
    ready = '1;
    cycle();
    for (int c = 0; c < CH; c++) begin
      checks++; if (valid_o[c] !== m_v[c] || dnum(c) != m_n[c]) begin
        failures++; $display("FAIL release_ch%0d got=v%0b/%0d exp=v%0b/%0d", c, valid_o[c], dnum(c), m_v[c], m_n[c]);
      end
    end
  endtask

  task automatic check_seq(input string name);
    int got[$];
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (valid_o[0]) got.push_back(dnum(0));
    end
    checks++; if (got.size() != ref_seq.size()) begin
      failures++; $display("FAIL %s_len got=%0d exp=%0d", name, got.size(), ref_seq.size());
    end
    for (int i = 0; i < got.size() && i < ref_seq.size(); i++) begin
      checks++; if (got[i] != ref_seq[i]) begin
        failures++; $display("FAIL %s_val[%0d] got=%0d exp=%0d", name, i, got[i], ref_seq[i]);
      end
    end
  endtask

  task automatic test_reseed();
    ready = '1; reseed = 1; seed = 32'h1;
    cycle();
    reseed = 0; seed = 32'h0;
    checks++; if (valid_o !== '0) begin failures++; $display("FAIL reseed_valid got=%b exp=0", valid_o); end
    checks++; if (seeded_o !== 1'b0) begin failures++; $display("FAIL reseed_seeded got=%0b exp=0", seeded_o); end
    cycle();
    checks++; if (seeded_o !== 1'b1 || valid_o !== '0) begin
      failures++; $display("FAIL reseed_load got=s%0b/v%b exp=s1/v0", seeded_o, valid_o);
    end
    check_seq("reseed_seq");
  endtask

  task automatic test_reset_reseed();
    rst = 1; reseed = 1; seed = 32'hBEEF;
    cycle();
    checks++; if (seeded_o !== 1'b0 || valid_o !== '0 || number_o !== '0 || reject_cnt_o !== 16'd0) begin
      failures++; $display("FAIL rst_reseed got=s%0b v%b n%h r%0d exp=all0", seeded_o, valid_o, number_o, reject_cnt_o);
    end
    rst = 0; seed = 32'hDEAD_BEEF;
    cycle();
    cycle();
    reseed = 0;
    checks++; if (seeded_o !== 1'b1) begin failures++; $display("FAIL ignored_reseed_seeded got=%0b exp=1", seeded_o); end
    check_seq("ignored_reseed_seq");
  endtask

  task automatic test_random();
    int hist [MV+1];
    int total;
    for (int i = 0; i <= MV; i++) hist[i] = 0;
    for (int k = 0; k < 20000; k++) begin
      ready = CH'($urandom);
      for (int c = 0; c < CH; c++) if (valid_o[c] && ready[c] && dnum(c) <= MV) hist[dnum(c)]++;
      cycle();
      for (int c = 0; c < CH; c++) begin
        checks++; if (valid_o[c] !== m_v[c] || dnum(c) != m_n[c] || dnum(c) > MV) begin
          failures++; $display("FAIL rand_ch%0d cyc=%0d got=v%0b/%0d exp=v%0b/%0d", c, k, valid_o[c], dnum(c), m_v[c], m_n[c]);
        end
      end
      checks++; if (int'(reject_cnt_o) != m_rej) begin
        failures++; $display("FAIL rand_rejcnt cyc=%0d got=%0d exp=%0d", k, reject_cnt_o, m_rej);
      end
    end
`ifdef SHUFFLEV_RNG_REJECT_EN
    total = 0;
    for (int i = 0; i <= MV; i++) total += hist[i];
    for (int i = 0; i <= MV; i++) begin
      checks++; if (hist[i] * (MV + 1) * 100 < total * 94 || hist[i] * (MV + 1) * 100 > total * 106) begin
        failures++; $display("FAIL uniform_%0d got=%0d exp~%0d", i, hist[i], total / (MV + 1));
      end
    end
    checks++; if (reject_cnt_o == 16'd0) begin failures++; $display("FAIL rejcnt_nonzero got=0 exp>0"); end
`else
    total = 0;
    for (int i = 0; i <= MV; i++) total += hist[i];
    checks++; if (total == 0) begin failures++; $display("FAIL rand_draws got=0 exp>0"); end
    checks++; if (reject_cnt_o !== 16'd0) begin failures++; $display("FAIL rejcnt_zero got=%0d exp=0", reject_cnt_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_startup();
    test_backpressure();
    test_reseed();
    test_reset_reseed();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
